// File: rtl/window_pkg.sv
// window_pkg: pixel and 3x3 window widths and types shared by the Mono8 window generator.
package window_pkg;
    localparam int PIX_W = 8;
    localparam int WIN_K = 3;
    localparam int WIN_W = PIX_W * WIN_K * WIN_K;
    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [WIN_W-1:0] win_t;
endpackage

// File: rtl/line_buffer_mono8.sv
// line_buffer_mono8: two-row line buffer, async read and in-place shift on write at one address.
module line_buffer_mono8
    import window_pkg::*;
#(
    parameter int DEPTH = 20
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [PIX_W-1:0]         din,
    output logic [PIX_W-1:0]         q0,
    output logic [PIX_W-1:0]         q1
);
    pix_t lb0 [DEPTH];
    pix_t lb1 [DEPTH];

    assign q0 = lb0[addr];
    assign q1 = lb1[addr];

    // No reset: rows 0-1 of every frame overwrite the contents before any window reads them.
    always_ff @(posedge clk) begin
        if (we) begin
            lb0[addr] <= lb1[addr];
            lb1[addr] <= din;
        end
    end
endmodule

// File: rtl/window_3x3_mono8.sv
// window_3x3_mono8: row-major Mono8 stream to valid-only 3x3 neighbourhoods, one output register.
// Define WINDOW_TLAST_EN to add m_axis_tlast (row-end and frame-end marker).
module window_3x3_mono8
    import window_pkg::*;
#(
    parameter int IN_ROWS = 20,
    parameter int IN_COLS = 20
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [PIX_W-1:0] s_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [WIN_W-1:0] m_axis_tdata,
`ifdef WINDOW_TLAST_EN
    output logic             m_axis_tlast,
`endif
    output logic             frame_done
);
    localparam int RW = $clog2(IN_ROWS);
    localparam int CW = $clog2(IN_COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - 1);
    localparam logic [RW-1:0] ROW_MIN = RW'(2);
    localparam logic [CW-1:0] COL_MIN = CW'(2);

    logic [RW-1:0] row;
    logic [CW-1:0] col;
    win_t          win_q;
    win_t          win_d;
    pix_t          a0;
    pix_t          a1;
    pix_t          new_col [WIN_K];
    logic          accept;
    logic          emit;
    logic          row_end;
    logic          frame_end;
    logic          out_frame_end;

    assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign row_end       = col == COL_LAST;
    assign frame_end     = row_end && row == ROW_LAST;
    assign emit          = accept && row >= ROW_MIN && col >= COL_MIN;
    assign frame_done    = m_axis_tvalid && m_axis_tready && out_frame_end;

    line_buffer_mono8 #(.DEPTH(IN_COLS)) u_lb (
        .clk (clk),
        .we  (accept),
        .addr(col),
        .din (s_axis_tdata),
        .q0  (a0),
        .q1  (a1)
    );

    // Each window row drops its oldest pixel (c=0) and takes the new column entry as c=2.
    always_comb begin
        new_col[0] = a0;
        new_col[1] = a1;
        new_col[2] = s_axis_tdata;
        win_d = win_q;
        for (int r = 0; r < WIN_K; r++)
            win_d[WIN_K*PIX_W*r +: WIN_K*PIX_W] = {new_col[r], win_q[WIN_K*PIX_W*r + PIX_W +: (WIN_K-1)*PIX_W]};
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            row           <= '0;
            col           <= '0;
            win_q         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            out_frame_end <= 1'b0;
        end else begin
            if (accept) begin
                win_q <= win_d;
                col   <= row_end ? '0 : col + 1'b1;
                row   <= frame_end ? '0 : row_end ? row + 1'b1 : row;
            end
            if (emit) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= win_d;
                out_frame_end <= frame_end;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

`ifdef WINDOW_TLAST_EN
    always_ff @(posedge clk) begin
        if (srst)
            m_axis_tlast <= 1'b0;
        else if (emit)
            m_axis_tlast <= row_end;
    end
`endif
endmodule

// File: tb/tb_window_3x3_mono8.sv
// tb_window_3x3_mono8: random and directed stimulus against an image-array reference model.
module tb_window_3x3_mono8;
    import window_pkg::*;
    localparam int R = 4;
    localparam int C = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        srst = 1'b1;
    logic        s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0, frame_done;
    logic [7:0]  s_data = '0;
    logic [71:0] m_data;
    logic        t_valid = 1'b0, t_ready, t_mvalid, t_done;
    logic [7:0]  t_data = '0;
    logic [71:0] t_mdata;
`ifdef WINDOW_TLAST_EN
    logic        m_last, t_last;
`endif

    window_3x3_mono8 #(.IN_ROWS(R), .IN_COLS(C)) dut (
        .clk(clk), .srst(srst),
        .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
        .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
`ifdef WINDOW_TLAST_EN
        .m_axis_tlast(m_last),
`endif
        .frame_done(frame_done)
    );

    window_3x3_mono8 #(.IN_ROWS(3), .IN_COLS(3)) dut3 (
        .clk(clk), .srst(srst),
        .s_axis_tvalid(t_valid), .s_axis_tready(t_ready), .s_axis_tdata(t_data),
        .m_axis_tvalid(t_mvalid), .m_axis_tready(1'b1), .m_axis_tdata(t_mdata),
`ifdef WINDOW_TLAST_EN
        .m_axis_tlast(t_last),
`endif
        .frame_done(t_done)
    );

    typedef struct {
        logic [71:0] data;
        logic        frame_end;
        logic        row_end;
    } exp_t;

    exp_t        exp_q[$];
    logic [71:0] obs_q[$];
    logic        obs_last_q[$];
    logic [7:0]  img [R][C];
    int          pos = 0;
    int          errors = 0;
    int          checks = 0;
    logic [7:0]  cur_pix;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [71:0] make_win(input int r, input int c);
        logic [71:0] w;
        for (int wr = 0; wr < 3; wr++)
            for (int wc = 0; wc < 3; wc++)
                w[8*(3*wr+wc) +: 8] = img[r-2+wr][c-2+wc];
        return w;
    endfunction

    function automatic void model_accept(input logic [7:0] p);
        int r = pos / C;
        int c = pos % C;
        img[r][c] = p;
        if (r >= 2 && c >= 2)
            exp_q.push_back('{make_win(r, c), r == R-1 && c == C-1, c == C-1});
        pos = (pos + 1) % (R * C);
    endfunction

    function automatic logic [7:0] next_pix(input bit rnd, input int base);
        return rnd ? 8'($urandom) : 8'(base + pos);
    endfunction

    // One cycle: drive at the falling edge, settle, then check and model the coming rising edge.
    task automatic step(input bit want_valid, input int vp, input int rp, output bit accepted);
        @(negedge clk);
        s_valid = want_valid && ($urandom_range(99) < vp);
        m_ready = $urandom_range(99) < rp;
        s_data  = cur_pix;
        #1;
        check("s_ready", 72'(s_ready), 72'(!m_valid || m_ready));
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_win", 72'(m_valid), 72'(0));
            end else begin
                check("win_data", m_data, exp_q[0].data);
`ifdef WINDOW_TLAST_EN
                check("tlast", 72'(m_last), 72'(exp_q[0].row_end));
`endif
                if (m_ready) begin
                    check("frame_done", 72'(frame_done), 72'(exp_q[0].frame_end));
                    obs_q.push_back(m_data);
                    obs_last_q.push_back(exp_q[0].row_end);
                    void'(exp_q.pop_front());
                end
            end
        end
        if (!(m_valid && m_ready))
            check("frame_done_idle", 72'(frame_done), 72'(0));
        accepted = s_valid && s_ready;
        if (accepted)
            model_accept(cur_pix);
    endtask

    task automatic feed(input int npix, input int base, input bit rnd, input int vp, input int rp);
        int got = 0;
        int cyc = 0;
        bit acc;
        cur_pix = next_pix(rnd, base);
        while (got < npix && cyc < 100 * npix + 100) begin
            step(1'b1, vp, rp, acc);
            cyc++;
            if (acc) begin
                got++;
                cur_pix = next_pix(rnd, base);
            end
        end
        if (got < npix)
            check("feed_timeout", 72'(got), 72'(npix));
    endtask

    task automatic drain(input int rp);
        int cyc = 0;
        bit acc;
        while ((exp_q.size() != 0 || m_valid) && cyc < 300) begin
            step(1'b0, 0, rp, acc);
            cyc++;
        end
        if (exp_q.size() != 0)
            check("drain_timeout", 72'(exp_q.size()), 72'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        srst    = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        t_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tvalid", 72'(m_valid), 72'(0));
        check("rst_tdata", m_data, 72'(0));
        check("rst_frame_done", 72'(frame_done), 72'(0));
        srst = 1'b0;
        exp_q.delete();
        obs_q.delete();
        obs_last_q.delete();
        pos = 0;
    endtask

    task automatic check_frame_index(input string tag);
        check({tag, "_count"}, 72'(obs_q.size()), 72'(6));
        if (obs_q.size() == 6) begin
            check({tag, "_first"}, obs_q[0], 72'h0c0b0a_070605_020100);
            check({tag, "_last"}, obs_q[5], 72'h131211_0e0d0c_090807);
        end
    endtask

    initial begin
        int n = 0;
        int got = 0;
        do_reset();

        feed(R * C, 0, 1'b0, 100, 100);
        drain(100);
        check_frame_index("s1");
`ifdef WINDOW_TLAST_EN
        if (obs_last_q.size() == 6)
            check("tlast_pattern", 72'({obs_last_q[5], obs_last_q[4], obs_last_q[3],
                                        obs_last_q[2], obs_last_q[1], obs_last_q[0]}), 72'(6'b100100));
`endif

        do_reset();
        feed(R * C, 0, 1'b0, 100, 33);
        drain(33);
        check_frame_index("s2");

        do_reset();
        feed(R * C, 0, 1'b0, 100, 100);
        feed(R * C, 100, 1'b0, 100, 100);
        drain(100);
        check("s3_count", 72'(obs_q.size()), 72'(12));
        if (obs_q.size() == 12)
            check("s3_first2", obs_q[6], 72'h706f6e_6b6a69_666564);

        do_reset();
        feed(9, 0, 1'b0, 100, 100);
        drain(100);
        check("s4_pre_reset", 72'(obs_q.size()), 72'(0));
        do_reset();
        feed(R * C, 0, 1'b0, 100, 100);
        drain(100);
        check_frame_index("s4");

        do_reset();
        feed(3 * R * C, 0, 1'b1, 70, 60);
        feed(7, 0, 1'b1, 70, 60);
        do_reset();
        feed(2 * R * C, 0, 1'b1, 80, 50);
        drain(50);

        do_reset();
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            t_valid = n < 9;
            t_data  = 8'(n);
            #1;
            if (t_mvalid) begin
                got++;
                check("s5_win", t_mdata, 72'h080706_050403_020100);
                check("s5_frame_done", 72'(t_done), 72'(1));
            end
            if (t_valid && t_ready)
                n++;
        end
        check("s5_count", 72'(got), 72'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
